coo_aggregation_block: RTL

Downstream neighbour of the transformation stage in the GCN accelerator. Consumes the FEATURE_ROWS x WEIGHT_COLS dot-product matrix (FM·WM), walks the COO edge list one edge per cycle to form (A+I)·(FM·WM), then reduces each node row to the index of its largest class score. Produces the per-node class address compared against the gold address file.

---
 rtl/gcn_pkg.sv | 23 ++
 rtl/max_address_finder.sv | 26 ++
 rtl/coo_aggregation_block.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gcn_pkg.sv
// Shared defaults and types for the GCN aggregation stage: parameter defaults,
// controller state encoding and one row of the FM*WM product matrix.
package gcn_pkg;

    localparam int FEATURE_ROWS_DEFAULT      = 6;
    localparam int WEIGHT_COLS_DEFAULT       = 3;
    localparam int DOT_PROD_WIDTH_DEFAULT    = 16;
    localparam int NUM_OF_NODES_DEFAULT      = 6;
    localparam int COO_NUM_OF_COLS_DEFAULT   = 6;
    localparam int COO_BW_DEFAULT            = $clog2(COO_NUM_OF_COLS_DEFAULT);
    localparam int MAX_ADDRESS_WIDTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        EDGE,
        ARGMAX,
        DONE
    } state_t;

    typedef logic [WEIGHT_COLS_DEFAULT-1:0][DOT_PROD_WIDTH_DEFAULT-1:0] row_t;

endpackage

// File: rtl/max_address_finder.sv
// Combinational argmax over one matrix row; unsigned compare, ties go to the
// lowest column index.
module max_address_finder #(
    parameter int WEIGHT_COLS       = gcn_pkg::WEIGHT_COLS_DEFAULT,
    parameter int DOT_PROD_WIDTH    = gcn_pkg::DOT_PROD_WIDTH_DEFAULT,
    parameter int MAX_ADDRESS_WIDTH = gcn_pkg::MAX_ADDRESS_WIDTH_DEFAULT
) (
    input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row,
    output logic [MAX_ADDRESS_WIDTH-1:0]               max_index
);

    logic [DOT_PROD_WIDTH-1:0] best_value;

    // Strict greater-than keeps the earliest column on equal values.
    always_comb begin
        max_index  = '0;
        best_value = row[0];
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (row[c] > best_value) begin
                best_value = row[c];
                max_index  = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/coo_aggregation_block.sv
// GCN aggregation: forms (A+I)*(FM*WM) by walking the COO edge list one edge per
// cycle, then reduces every node row to the column index of its largest score.
module coo_aggregation_block
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS      = FEATURE_ROWS_DEFAULT,
    parameter int WEIGHT_COLS       = WEIGHT_COLS_DEFAULT,
    parameter int DOT_PROD_WIDTH    = DOT_PROD_WIDTH_DEFAULT,
    parameter int NUM_OF_NODES      = NUM_OF_NODES_DEFAULT,
    parameter int COO_NUM_OF_COLS   = COO_NUM_OF_COLS_DEFAULT,
    parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
    parameter int MAX_ADDRESS_WIDTH = MAX_ADDRESS_WIDTH_DEFAULT
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic                                                     start,
    input  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in,
    output logic [COO_BW-1:0]                                        coo_address,
    output logic                                                     coo_read_enable,
    input  logic [2*COO_BW-1:0]                                      coo_in,
    output logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] agg_out,
    output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]           max_addi_answer,
    output logic                                                     coo_error,
    output logic                                                     done
);

    localparam int NODE_BW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;

    state_t state, next_state;

    logic [COO_BW-1:0]  edge_cnt;
    logic [NODE_BW-1:0] node_cnt;
    logic [COO_BW-1:0]  node_a, node_b;
    logic               edge_bad, last_edge, last_node;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_a, row_b, arg_row;
    logic [MAX_ADDRESS_WIDTH-1:0] arg_index;

    assign node_a      = coo_in[2*COO_BW-1:COO_BW];
    assign node_b      = coo_in[COO_BW-1:0];
    assign edge_bad    = (int'(node_a) >= NUM_OF_NODES) || (int'(node_b) >= NUM_OF_NODES);
    assign last_edge   = (edge_cnt == COO_BW'(COO_NUM_OF_COLS - 1));
    assign last_node   = (node_cnt == NODE_BW'(FEATURE_ROWS - 1));
    assign coo_address = edge_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state      = state;
        coo_read_enable = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE:   if (start) next_state = INIT;
            INIT:   next_state = EDGE;
            EDGE: begin
                coo_read_enable = 1'b1;
                if (last_edge) next_state = ARGMAX;
            end
            ARGMAX: if (last_node) next_state = DONE;
            DONE: begin
                done = 1'b1;
                if (!start) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Row selection by compare-and-pick so an out-of-range node index never
    // produces an out-of-bounds array access.
    always_comb begin
        row_a   = '0;
        row_b   = '0;
        arg_row = '0;
        for (int i = 0; i < FEATURE_ROWS; i++) begin
            if (COO_BW'(i) == node_a)   row_a   = fm_wm_in[i];
            if (COO_BW'(i) == node_b)   row_b   = fm_wm_in[i];
            if (NODE_BW'(i) == node_cnt) arg_row = agg_out[i];
        end
    end

    max_address_finder #(
        .WEIGHT_COLS      (WEIGHT_COLS),
        .DOT_PROD_WIDTH   (DOT_PROD_WIDTH),
        .MAX_ADDRESS_WIDTH(MAX_ADDRESS_WIDTH)
    ) u_max_address_finder (
        .row      (arg_row),
        .max_index(arg_index)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt        <= '0;
            node_cnt        <= '0;
            agg_out         <= '0;
            max_addi_answer <= '0;
            coo_error       <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    agg_out   <= fm_wm_in;
                    coo_error <= 1'b0;
                    edge_cnt  <= '0;
                    node_cnt  <= '0;
                end
                EDGE: begin
                    edge_cnt <= last_edge ? '0 : edge_cnt + COO_BW'(1);
                    if (edge_bad) begin
                        coo_error <= 1'b1;
                    end else if (node_a != node_b) begin
                        // Undirected edge: both endpoints gather the other's row.
                        for (int i = 0; i < FEATURE_ROWS; i++) begin
                            for (int c = 0; c < WEIGHT_COLS; c++) begin
                                if (COO_BW'(i) == node_a)
                                    agg_out[i][c] <= agg_out[i][c] + row_b[c];
                                else if (COO_BW'(i) == node_b)
                                    agg_out[i][c] <= agg_out[i][c] + row_a[c];
                            end
                        end
                    end
                end
                ARGMAX: begin
                    node_cnt <= last_node ? '0 : node_cnt + NODE_BW'(1);
                    for (int i = 0; i < FEATURE_ROWS; i++) begin
                        if (NODE_BW'(i) == node_cnt) max_addi_answer[i] <= arg_index;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
